// File: rtl/addsub_pkg.sv
// addsub_pkg: op and state codes shared by the chunked add/sub unit
package addsub_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SLT = 2'b10, OP_RSVD = 2'b11} op_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10} state_t;
  function automatic logic is_sub(input logic [1:0] op);
    return op == OP_SUB || op == OP_SLT;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit ripple adder of full-adder cells, exposing the carry into the MSB
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/chunked_addsub_unit.sv
// chunked_addsub_unit: multi-cycle ADD/SUB/SLT, CHUNK bits per cycle over WIDTH/CHUNK cycles.
// Define ADDSUB_SAT_EN to saturate ADD/SUB results on signed overflow.
module chunked_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = $clog2(NCHUNK) + 1;
  state_t state, state_n;
  op_t op_r;
  logic [CW-1:0] k;
  logic [WIDTH-1:0] a_r, b_r, s_r, s_full, res_n;
  logic [CHUNK-1:0] sum;
  logic cy, cout, cmsb, ovf, lt, last, sub;
  assign sub = is_sub(op);
  assign last = k == CW'(NCHUNK - 1);
  assign in_ready = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  // Operands shift right each cycle so the active chunk always sits at bit 0.
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a_r[CHUNK-1:0]),
    .b(b_r[CHUNK-1:0]),
    .cin(cy),
    .sum(sum),
    .cout(cout),
    .cmsb(cmsb)
  );
  // Carry-in ^ carry-out of the sign bit equals the sign-based overflow test.
  assign ovf = cmsb ^ cout;
  assign lt = sum[CHUNK-1] ^ ovf;
  assign s_full = WIDTH'({sum, s_r} >> CHUNK);
  always_comb begin
    res_n = op_r == OP_SLT ? WIDTH'(lt) : s_full;
`ifdef ADDSUB_SAT_EN
    if (op_r != OP_SLT && ovf)
      res_n = a_r[CHUNK-1] ? (WIDTH'(1) << (WIDTH - 1)) : ~(WIDTH'(1) << (WIDTH - 1));
`endif
  end
  always_comb begin
    state_n = state == ST_IDLE ? (in_valid ? ST_RUN : ST_IDLE) :
              state == ST_RUN  ? (last ? ST_DONE : ST_RUN) :
                                 (out_ready ? ST_IDLE : ST_DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      s_r <= '0;
      op_r <= OP_ADD;
      cy <= 1'b0;
      k <= '0;
      result <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_r <= a;
      b_r <= b ^ {WIDTH{sub}};
      op_r <= op_t'(op);
      cy <= sub;
      k <= '0;
    end else if (state == ST_RUN) begin
      a_r <= a_r >> CHUNK;
      b_r <= b_r >> CHUNK;
      s_r <= s_full;
      cy <= cout;
      k <= k + CW'(1);
      if (last) begin
        result <= res_n;
        carryout <= cout;
        overflow <= ovf;
        zero <= res_n == '0;
      end
    end
  end
endmodule

// File: tb/tb_chunked_addsub_unit.sv
// tb_chunked_addsub_unit: table-driven check of four unit instances (CHUNK=2,1,5,10) sharing one stimulus
module tb_chunked_addsub_unit;
  localparam int CH [4] = '{2, 1, 5, 10};
  typedef struct {
    logic [1:0] op;
    logic [9:0] a, b, r;
    logic c, o, z;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [1:0] op = 0;
  logic [9:0] a = 0, b = 0;
  logic rdy [4], vld [4], co [4], of [4], zf [4];
  logic [9:0] res [4];
  vec_t tv [13];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    chunked_addsub_unit #(.WIDTH(10), .CHUNK(CH[g])) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[g]), .op(op),
      .a(a), .b(b), .out_valid(vld[g]), .out_ready(out_ready), .result(res[g]),
      .carryout(co[g]), .overflow(of[g]), .zero(zf[g])
    );
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic idle_chk(input string nm);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s.c%0d.vld", nm, CH[g]), 32'(vld[g]), 0);
      chk($sformatf("%s.c%0d.rdy", nm, CH[g]), 32'(rdy[g]), 1);
    end
  endtask
  task automatic run(input int i);
    int lat [4];
    logic [9:0] snap [4];
    @(negedge clk);
    op = tv[i].op; a = tv[i].a; b = tv[i].b; in_valid = 1;
    @(posedge clk); #1;
    op = ~op; a = ~a; b = b + 10'd7;
    for (int g = 0; g < 4; g++) begin lat[g] = -1; snap[g] = 'x; end
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++)
        if (vld[g] && lat[g] < 0) begin lat[g] = c; snap[g] = res[g]; end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("v%0d.c%0d.lat", i, CH[g]), 32'(lat[g]), 32'(10 / CH[g]));
      chk($sformatf("v%0d.c%0d.rdy", i, CH[g]), 32'(rdy[g]), 0);
      chk($sformatf("v%0d.c%0d.res", i, CH[g]), 32'(res[g]), 32'(tv[i].r));
      chk($sformatf("v%0d.c%0d.hold", i, CH[g]), 32'(res[g]), 32'(snap[g]));
      chk($sformatf("v%0d.c%0d.carry", i, CH[g]), 32'(co[g]), 32'(tv[i].c));
      chk($sformatf("v%0d.c%0d.ovf", i, CH[g]), 32'(of[g]), 32'(tv[i].o));
      chk($sformatf("v%0d.c%0d.zero", i, CH[g]), 32'(zf[g]), 32'(tv[i].z));
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    idle_chk($sformatf("v%0d.hs", i));
    out_ready = 0;
  endtask
  initial begin
    tv[0]  = '{2'b00, 10'd100, 10'd200, 10'd300, 0, 0, 0};
    tv[1]  = '{2'b01, 10'd5, 10'd7, 10'h3FE, 0, 0, 0};
    tv[2]  = '{2'b01, 10'd37, 10'd37, 10'h000, 1, 0, 1};
`ifdef ADDSUB_SAT_EN
    tv[3]  = '{2'b00, 10'h1FF, 10'h001, 10'h1FF, 0, 1, 0};
    tv[9]  = '{2'b01, 10'h200, 10'h001, 10'h200, 1, 1, 0};
`else
    tv[3]  = '{2'b00, 10'h1FF, 10'h001, 10'h200, 0, 1, 0};
    tv[9]  = '{2'b01, 10'h200, 10'h001, 10'h1FF, 1, 1, 0};
`endif
    tv[4]  = '{2'b10, 10'h200, 10'h001, 10'h001, 1, 1, 0};
    tv[5]  = '{2'b10, 10'd3, 10'd3, 10'h000, 1, 0, 1};
    tv[6]  = '{2'b00, 10'h3FF, 10'h001, 10'h000, 1, 0, 1};
    tv[7]  = '{2'b11, 10'd50, 10'd25, 10'd75, 0, 0, 0};
    tv[8]  = '{2'b10, 10'h3FE, 10'd5, 10'h001, 1, 0, 0};
    tv[10] = '{2'b10, 10'd5, 10'h3FE, 10'h000, 0, 0, 1};
    tv[11] = '{2'b00, 10'h155, 10'h0AA, 10'h1FF, 0, 0, 0};
    tv[12] = '{2'b00, 10'd1, 10'd1, 10'd2, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    idle_chk("rst");
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst.c%0d.res", CH[g]), 32'(res[g]), 0);
      chk($sformatf("rst.c%0d.flags", CH[g]), 32'({co[g], of[g], zf[g]}), 0);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) run(i);
    // Reset asserted while the CHUNK=2 instance works on chunk 2.
    @(negedge clk);
    op = 2'b00; a = 10'd100; b = 10'd200; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    idle_chk("midrst");
    for (int g = 0; g < 4; g++)
      chk($sformatf("midrst.c%0d.res", CH[g]), 32'(res[g]), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(posedge clk);
    #1;
    idle_chk("postrst");
    run(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
